// File: rtl/rr4_switch_sched_if.sv
// Scheduler <-> FIFO bank signal bundle for rr4_switch_sched.
// master: the scheduler (drives pop/push strobes); slave: the FIFO bank side.
interface rr4_switch_sched_if #(
    parameter int unsigned DW = 10
);
    logic [3:0]    in_empty;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic [DW-1:0] in_data2;
    logic [DW-1:0] in_data3;
    logic [3:0]    out_full;
    logic [3:0]    pop;
    logic [3:0]    push;
    logic [DW-1:0] data_out;
    logic [1:0]    grant_id;
    logic          busy;
    logic          drop;

    modport master (
        input  in_empty, in_data0, in_data1, in_data2, in_data3, out_full,
        output pop, push, data_out, grant_id, busy, drop
    );

    modport slave (
        output in_empty, in_data0, in_data1, in_data2, in_data3, out_full,
        input  pop, push, data_out, grant_id, busy, drop
    );
endinterface

// File: rtl/rr4_switch_sched.sv
// Round-robin scheduler for a 4-in / 4-out word switch. Pops one word from a
// non-empty input FIFO, captures it, and pushes it to the output FIFO named by
// its destination field, holding it until that output has room.
// Optional macro SCHED_DROP_EN: discard a word after TIMEOUT stalled SEND cycles.
module rr4_switch_sched #(
    parameter int unsigned DW       = 10,
    parameter int unsigned DEST_MSB = 9,
    parameter int unsigned DEST_LSB = 8
`ifdef SCHED_DROP_EN
    ,
    parameter int unsigned TIMEOUT  = 15
`endif
) (
    input logic                 clk,
    input logic                 reset,
    rr4_switch_sched_if.master  io_sched
);

    typedef enum logic [1:0] {StIdle, StPop, StCapt, StSend} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [1:0]    r_ptr;
    logic [1:0]    r_grant;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_in_data;
    logic [1:0]    w_sel;
    logic [1:0]    w_dest;
    logic          w_found;
    logic          w_push_ok;
    logic          w_drop;

    // First non-empty input at or after the pointer; descending scan so the
    // smallest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (!io_sched.in_empty[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_sel   = r_ptr + 2'(k);
            end
        end
    end

    // Read data of the granted input FIFO
    always_comb begin
        case (r_grant)
            2'd0:    w_in_data = io_sched.in_data0;
            2'd1:    w_in_data = io_sched.in_data1;
            2'd2:    w_in_data = io_sched.in_data2;
            default: w_in_data = io_sched.in_data3;
        endcase
    end

    assign w_dest    = r_data[DEST_MSB:DEST_LSB];
    assign w_push_ok = (r_state == StSend) && !io_sched.out_full[w_dest];

`ifdef SCHED_DROP_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // Stall counter: cleared during CAPT so it reads zero on SEND entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == StCapt) begin
            r_cnt <= '0;
        end else if ((r_state == StSend) && !w_push_ok && !w_drop) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_drop = (r_state == StSend) && !w_push_ok && (r_cnt == CW'(TIMEOUT));
`else
    assign w_drop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_found) w_state_next = StPop;
            StPop:   w_state_next = StCapt;
            StCapt:  w_state_next = StSend;
            StSend:  if (w_push_ok || w_drop) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Grant, captured word and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
            r_data  <= '0;
        end else begin
            if ((r_state == StIdle) && w_found) r_grant <= w_sel;
            if (r_state == StCapt) r_data <= w_in_data;
            // Pointer only moves once the word has left, pushed or dropped
            if (w_push_ok || w_drop) r_ptr <= r_grant + 2'd1;
        end
    end

    // Output strobes and status
    always_comb begin
        io_sched.pop      = 4'b0000;
        io_sched.push     = 4'b0000;
        if (r_state == StPop) io_sched.pop[r_grant] = 1'b1;
        if (w_push_ok) io_sched.push[w_dest] = 1'b1;
        io_sched.busy     = (r_state != StIdle);
        io_sched.drop     = w_drop;
        io_sched.data_out = r_data;
        io_sched.grant_id = r_grant;
    end

endmodule
